// File: rtl/branch_hazard_ctrl_if.sv
// ID-stage hazard/branch control bundle between the pipeline (master) and branch_hazard_ctrl (slave).
interface branch_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);
  logic                  id_branch;
  logic                  id_uses_rs1;
  logic                  id_uses_rs2;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic [REG_ADDR_W-1:0] id_ex_rd;
  logic                  id_ex_regWrite;
  logic                  id_ex_memRead;
  logic [REG_ADDR_W-1:0] ex_mem_rd;
  logic                  ex_mem_memRead;
  logic                  equal_to;

  logic                  pc_write;
  logic                  if_id_write;
  logic                  id_ex_bubble;
  logic                  pc_src;
  logic                  if_id_flush;
  logic                  stall_active;
  logic [CNT_W-1:0]      perf_branches;
  logic [CNT_W-1:0]      perf_taken;
  logic [CNT_W-1:0]      perf_stalls;

  modport master (
    output id_branch, id_uses_rs1, id_uses_rs2, id_rs1, id_rs2,
           id_ex_rd, id_ex_regWrite, id_ex_memRead, ex_mem_rd, ex_mem_memRead, equal_to,
    input  pc_write, if_id_write, id_ex_bubble, pc_src, if_id_flush, stall_active,
           perf_branches, perf_taken, perf_stalls
  );

  modport slave (
    input  id_branch, id_uses_rs1, id_uses_rs2, id_rs1, id_rs2,
           id_ex_rd, id_ex_regWrite, id_ex_memRead, ex_mem_rd, ex_mem_memRead, equal_to,
    output pc_write, if_id_write, id_ex_bubble, pc_src, if_id_flush, stall_active,
           perf_branches, perf_taken, perf_stalls
  );
endinterface

// File: rtl/branch_hazard_ctrl.sv
// Stall sequencer and branch resolver for the ID-stage compare path.
// Optional perf counters are built only when BRANCH_PERF_CNT_EN is defined.
module branch_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int EX_ALU_FWD = 1,
  parameter int CNT_W      = 32
) (
  input logic                i_clock,
  input logic                i_reset,
  branch_hazard_ctrl_if.slave bus
);

  typedef enum logic {S_RUN, S_STALL} state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_stall_cnt;
  logic [1:0] w_stall_cnt_nxt;
  logic [1:0] w_need;
  logic [1:0] w_need_rs1;
  logic [1:0] w_need_rs2;
  logic       w_pc_write;
  logic       w_if_id_write;
  logic       w_id_ex_bubble;
  logic       w_pc_src;
  logic       w_if_id_flush;
  logic       w_stall_active;

  function automatic logic f_match(input logic used,
                                   input logic [REG_ADDR_W-1:0] rs,
                                   input logic [REG_ADDR_W-1:0] rd);
    return used && (rd != '0) && (rd == rs);
  endfunction

  // Checks are ordered by descending cost so the first hit is the per-source maximum.
  function automatic logic [1:0] f_src_need(input logic ex_m, input logic mem_m);
    if (ex_m && bus.id_ex_memRead)
      return bus.id_branch ? 2'd2 : 2'd1;
    else if (mem_m && bus.ex_mem_memRead && bus.id_branch)
      return 2'd1;
    else if (ex_m && bus.id_ex_regWrite && bus.id_branch && (EX_ALU_FWD == 0))
      return 2'd1;
    else
      return 2'd0;
  endfunction

  always_comb begin
    w_need_rs1 = f_src_need(f_match(bus.id_uses_rs1, bus.id_rs1, bus.id_ex_rd),
                            f_match(bus.id_uses_rs1, bus.id_rs1, bus.ex_mem_rd));
    w_need_rs2 = f_src_need(f_match(bus.id_uses_rs2, bus.id_rs2, bus.id_ex_rd),
                            f_match(bus.id_uses_rs2, bus.id_rs2, bus.ex_mem_rd));
    w_need     = (w_need_rs1 > w_need_rs2) ? w_need_rs1 : w_need_rs2;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= S_RUN;
      r_stall_cnt <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_stall_cnt <= w_stall_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_stall_cnt_nxt = r_stall_cnt;
    w_pc_write      = 1'b1;
    w_if_id_write   = 1'b1;
    w_id_ex_bubble  = 1'b0;
    w_pc_src        = 1'b0;
    w_if_id_flush   = 1'b0;
    w_stall_active  = 1'b0;
    if (i_reset) begin
      w_pc_write     = 1'b0;
      w_if_id_write  = 1'b0;
      w_id_ex_bubble = 1'b1;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_need != 2'd0) begin
            w_state_nxt     = S_STALL;
            w_stall_cnt_nxt = w_need - 2'd1;
            w_pc_write      = 1'b0;
            w_if_id_write   = 1'b0;
            w_id_ex_bubble  = 1'b1;
          end else if (bus.id_branch) begin
            w_pc_src      = bus.equal_to;
            w_if_id_flush = bus.equal_to;
          end
        end
        S_STALL: begin
          w_pc_write     = 1'b0;
          w_if_id_write  = 1'b0;
          w_id_ex_bubble = 1'b1;
          w_stall_active = 1'b1;
          if (r_stall_cnt == 2'd0)
            w_state_nxt = S_RUN;
          else
            w_stall_cnt_nxt = r_stall_cnt - 2'd1;
        end
        default: w_state_nxt = S_RUN;
      endcase
    end
  end

  assign bus.pc_write     = w_pc_write;
  assign bus.if_id_write  = w_if_id_write;
  assign bus.id_ex_bubble = w_id_ex_bubble;
  assign bus.pc_src       = w_pc_src;
  assign bus.if_id_flush  = w_if_id_flush;
  assign bus.stall_active = w_stall_active;

`ifdef BRANCH_PERF_CNT_EN
  logic [CNT_W-1:0] r_perf_branches;
  logic [CNT_W-1:0] r_perf_taken;
  logic [CNT_W-1:0] r_perf_stalls;
  logic             w_resolve;

  assign w_resolve = !i_reset && (r_state == S_RUN) && (w_need == 2'd0) && bus.id_branch;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_perf_branches <= '0;
      r_perf_taken    <= '0;
      r_perf_stalls   <= '0;
    end else begin
      if (w_resolve)
        r_perf_branches <= r_perf_branches + 1'b1;
      if (w_resolve && bus.equal_to)
        r_perf_taken <= r_perf_taken + 1'b1;
      if (w_id_ex_bubble)
        r_perf_stalls <= r_perf_stalls + 1'b1;
    end
  end

  assign bus.perf_branches = r_perf_branches;
  assign bus.perf_taken    = r_perf_taken;
  assign bus.perf_stalls   = r_perf_stalls;
`else
  assign bus.perf_branches = {CNT_W{1'b0}};
  assign bus.perf_taken    = {CNT_W{1'b0}};
  assign bus.perf_stalls   = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed bench for branch_hazard_ctrl: one DUT with EX ALU forwarding, one without.
module tb_branch_hazard_ctrl;
  logic       clock = 1'b0;
  logic       reset;
  logic       id_branch, id_uses_rs1, id_uses_rs2;
  logic [4:0] id_rs1, id_rs2, id_ex_rd, ex_mem_rd;
  logic       id_ex_regWrite, id_ex_memRead, ex_mem_memRead, equal_to;
  int         checks   = 0;
  int         failures = 0;

  // output vector: {pc_write, if_id_write, id_ex_bubble, pc_src, if_id_flush, stall_active}
  localparam logic [5:0] NORM  = 6'b110000;
  localparam logic [5:0] TAKEN = 6'b110110;
  localparam logic [5:0] HOLD  = 6'b001000;
  localparam logic [5:0] STL   = 6'b001001;
  localparam logic [5:0] RSTV  = 6'b001000;

  always #5 clock = ~clock;

  branch_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(32)) if_a ();
  branch_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(32)) if_b ();

  assign if_a.id_branch      = id_branch;
  assign if_a.id_uses_rs1    = id_uses_rs1;
  assign if_a.id_uses_rs2    = id_uses_rs2;
  assign if_a.id_rs1         = id_rs1;
  assign if_a.id_rs2         = id_rs2;
  assign if_a.id_ex_rd       = id_ex_rd;
  assign if_a.id_ex_regWrite = id_ex_regWrite;
  assign if_a.id_ex_memRead  = id_ex_memRead;
  assign if_a.ex_mem_rd      = ex_mem_rd;
  assign if_a.ex_mem_memRead = ex_mem_memRead;
  assign if_a.equal_to       = equal_to;
  assign if_b.id_branch      = id_branch;
  assign if_b.id_uses_rs1    = id_uses_rs1;
  assign if_b.id_uses_rs2    = id_uses_rs2;
  assign if_b.id_rs1         = id_rs1;
  assign if_b.id_rs2         = id_rs2;
  assign if_b.id_ex_rd       = id_ex_rd;
  assign if_b.id_ex_regWrite = id_ex_regWrite;
  assign if_b.id_ex_memRead  = id_ex_memRead;
  assign if_b.ex_mem_rd      = ex_mem_rd;
  assign if_b.ex_mem_memRead = ex_mem_memRead;
  assign if_b.equal_to       = equal_to;

  branch_hazard_ctrl #(.REG_ADDR_W(5), .EX_ALU_FWD(1), .CNT_W(32)) u_fwd (
    .i_clock (clock),
    .i_reset (reset),
    .bus     (if_a.slave)
  );

  branch_hazard_ctrl #(.REG_ADDR_W(5), .EX_ALU_FWD(0), .CNT_W(32)) u_nofwd (
    .i_clock (clock),
    .i_reset (reset),
    .bus     (if_b.slave)
  );

  wire [5:0]  obs_a  = {if_a.pc_write, if_a.if_id_write, if_a.id_ex_bubble,
                        if_a.pc_src, if_a.if_id_flush, if_a.stall_active};
  wire [5:0]  obs_b  = {if_b.pc_write, if_b.if_id_write, if_b.id_ex_bubble,
                        if_b.pc_src, if_b.if_id_flush, if_b.stall_active};
  wire [95:0] perf_a = {if_a.perf_branches, if_a.perf_taken, if_a.perf_stalls};

  task automatic clear_in();
    id_branch = 0; id_uses_rs1 = 0; id_uses_rs2 = 0; id_rs1 = 0; id_rs2 = 0;
    id_ex_rd = 0; id_ex_regWrite = 0; id_ex_memRead = 0;
    ex_mem_rd = 0; ex_mem_memRead = 0; equal_to = 0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    clear_in();
    reset = 1;
    step();
    step();
    reset = 0;
  endtask

  task automatic set_beq(input logic [4:0] rs1, input logic [4:0] rs2, input logic eq);
    id_branch = 1; id_uses_rs1 = 1; id_uses_rs2 = 1; id_rs1 = rs1; id_rs2 = rs2; equal_to = eq;
  endtask

  task automatic test_reset();
    clear_in();
    reset = 1;
    id_ex_rd = 5; id_ex_memRead = 1; id_ex_regWrite = 1;
    set_beq(5, 6, 1);
    step();
    checks++; if (obs_a !== RSTV) begin failures++; $display("FAIL reset_out_fwd: got %b want %b", obs_a, RSTV); end
    checks++; if (obs_b !== RSTV) begin failures++; $display("FAIL reset_out_nofwd: got %b want %b", obs_b, RSTV); end
    checks++; if (perf_a !== 96'd0) begin failures++; $display("FAIL reset_perf: got %h want 0", perf_a); end
    clear_in();
    reset = 0;
    #1;
    checks++; if (obs_a !== NORM) begin failures++; $display("FAIL reset_release: got %b want %b", obs_a, NORM); end
  endtask

  task automatic test_load_ex_branch();
    do_reset();
    id_ex_rd = 5; id_ex_memRead = 1; id_ex_regWrite = 1;
    set_beq(5, 6, 1);
    #1;
    checks++; if (obs_a !== HOLD) begin failures++; $display("FAIL t1_detect: got %b want %b", obs_a, HOLD); end
    step();
    id_ex_rd = 0; id_ex_memRead = 0; id_ex_regWrite = 0;
    #1;
    checks++; if (obs_a !== STL) begin failures++; $display("FAIL t1_stall1: got %b want %b", obs_a, STL); end
    step();
    checks++; if (obs_a !== STL) begin failures++; $display("FAIL t1_stall2: got %b want %b", obs_a, STL); end
    step();
    checks++; if (obs_a !== TAKEN) begin failures++; $display("FAIL t1_resolve: got %b want %b", obs_a, TAKEN); end
    step();
    clear_in();
    #1;
    checks++; if (obs_a !== NORM) begin failures++; $display("FAIL t1_after: got %b want %b", obs_a, NORM); end
  endtask

  task automatic test_load_mem_branch();
    do_reset();
    ex_mem_rd = 5; ex_mem_memRead = 1;
    set_beq(6, 5, 1);
    #1;
    checks++; if (obs_a !== HOLD) begin failures++; $display("FAIL t2_detect: got %b want %b", obs_a, HOLD); end
    step();
    ex_mem_rd = 0; ex_mem_memRead = 0;
    #1;
    checks++; if (obs_a !== STL) begin failures++; $display("FAIL t2_stall: got %b want %b", obs_a, STL); end
    step();
    equal_to = 0;
    #1;
    checks++; if (obs_a !== NORM) begin failures++; $display("FAIL t2_resolve_nt: got %b want %b", obs_a, NORM); end
  endtask

  task automatic test_alu_fwd();
    do_reset();
    id_ex_rd = 7; id_ex_regWrite = 1;
    set_beq(7, 0, 1);
    #1;
    checks++; if (obs_a !== TAKEN) begin failures++; $display("FAIL t3_fwd_resolve: got %b want %b", obs_a, TAKEN); end
    checks++; if (obs_b !== HOLD) begin failures++; $display("FAIL t3_nofwd_detect: got %b want %b", obs_b, HOLD); end
    step();
    id_ex_rd = 0; id_ex_regWrite = 0;
    #1;
    checks++; if (obs_b !== STL) begin failures++; $display("FAIL t3_nofwd_stall: got %b want %b", obs_b, STL); end
    step();
    checks++; if (obs_b !== TAKEN) begin failures++; $display("FAIL t3_nofwd_resolve: got %b want %b", obs_b, TAKEN); end
    clear_in();
    id_ex_rd = 7; id_ex_regWrite = 1; id_uses_rs1 = 1; id_rs1 = 7;
    #1;
    checks++; if (obs_b !== NORM) begin failures++; $display("FAIL t3_nofwd_nonbranch: got %b want %b", obs_b, NORM); end
  endtask

  task automatic test_zero_reg();
    do_reset();
    id_ex_rd = 0; id_ex_memRead = 1; id_ex_regWrite = 1;
    set_beq(0, 0, 1);
    #1;
    checks++; if (obs_a !== TAKEN) begin failures++; $display("FAIL t4_x0_fwd: got %b want %b", obs_a, TAKEN); end
    checks++; if (obs_b !== TAKEN) begin failures++; $display("FAIL t4_x0_nofwd: got %b want %b", obs_b, TAKEN); end
    step();
    clear_in();
    id_ex_rd = 9; id_ex_memRead = 1; id_ex_regWrite = 1;
    id_rs1 = 9; id_uses_rs2 = 1; id_rs2 = 3;
    #1;
    checks++; if (obs_a !== NORM) begin failures++; $display("FAIL t4_unused_src: got %b want %b", obs_a, NORM); end
    id_ex_rd = 0; id_ex_memRead = 0; id_ex_regWrite = 0;
    ex_mem_rd = 9; ex_mem_memRead = 1; id_uses_rs1 = 1;
    #1;
    checks++; if (obs_a !== NORM) begin failures++; $display("FAIL t4_mem_load_nonbranch: got %b want %b", obs_a, NORM); end
    ex_mem_rd = 0; ex_mem_memRead = 0;
    id_ex_rd = 9; id_ex_memRead = 1; id_ex_regWrite = 1;
    #1;
    checks++; if (obs_a !== HOLD) begin failures++; $display("FAIL t4_loaduse_detect: got %b want %b", obs_a, HOLD); end
    step();
    id_ex_rd = 0; id_ex_memRead = 0; id_ex_regWrite = 0;
    #1;
    checks++; if (obs_a !== STL) begin failures++; $display("FAIL t4_loaduse_stall: got %b want %b", obs_a, STL); end
    step();
    checks++; if (obs_a !== NORM) begin failures++; $display("FAIL t4_loaduse_release: got %b want %b", obs_a, NORM); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    id_ex_rd = 5; id_ex_memRead = 1; id_ex_regWrite = 1;
    set_beq(5, 6, 1);
    step();
    checks++; if (obs_a !== STL) begin failures++; $display("FAIL t5_in_stall: got %b want %b", obs_a, STL); end
    clear_in();
    reset = 1;
    #1;
    checks++; if (obs_a !== RSTV) begin failures++; $display("FAIL t5_reset_out: got %b want %b", obs_a, RSTV); end
    step();
    reset = 0;
    #1;
    checks++; if (obs_a !== NORM) begin failures++; $display("FAIL t5_run_after: got %b want %b", obs_a, NORM); end
    checks++; if (perf_a !== 96'd0) begin failures++; $display("FAIL t5_perf_zero: got %h want 0", perf_a); end
    step();
    checks++; if (obs_a !== NORM) begin failures++; $display("FAIL t5_abandoned: got %b want %b", obs_a, NORM); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_beq(1, 2, 1);
    #1;
    checks++; if (obs_a !== TAKEN) begin failures++; $display("FAIL b2b_first: got %b want %b", obs_a, TAKEN); end
    step();
    equal_to = 0;
    #1;
    checks++; if (obs_a !== NORM) begin failures++; $display("FAIL b2b_second_nt: got %b want %b", obs_a, NORM); end
    step();
    equal_to = 1;
    #1;
    checks++; if (obs_a !== TAKEN) begin failures++; $display("FAIL b2b_third: got %b want %b", obs_a, TAKEN); end
    step();
    id_branch = 0;
    #1;
    checks++; if (obs_a !== NORM) begin failures++; $display("FAIL b2b_eq_ignored: got %b want %b", obs_a, NORM); end
  endtask

  task automatic test_perf();
    logic [95:0] exp_perf;
    do_reset();
    id_ex_rd = 5; id_ex_memRead = 1; id_ex_regWrite = 1;
    set_beq(5, 6, 1);
    step();
    id_ex_rd = 0; id_ex_memRead = 0; id_ex_regWrite = 0;
    step();
    step();
    step();
    equal_to = 0;
    step();
    equal_to = 1;
    step();
    clear_in();
`ifdef BRANCH_PERF_CNT_EN
    exp_perf = {32'd3, 32'd2, 32'd3};
`else
    exp_perf = 96'd0;
`endif
    #1;
    checks++; if (perf_a !== exp_perf) begin failures++; $display("FAIL perf_counts: got %h want %h", perf_a, exp_perf); end
  endtask

  initial begin
    clear_in();
    reset = 1;
    test_reset();
    test_load_ex_branch();
    test_load_mem_branch();
    test_alu_fwd();
    test_zero_reg();
    test_reset_mid_stall();
    test_back_to_back();
    test_perf();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
